// File: rtl/prbs8_pkg.sv
// prbs8_pkg: state encoding, default thresholds and feedback helper shared by the PRBS8 checker files
package prbs8_pkg;
  typedef enum logic [1:0] {FILL, HUNT, LOCK} state_t;
  localparam int LOCK_CNT_DEF = 16;
  localparam int UNLOCK_ERRS_DEF = 4;
  function automatic logic prbs8_fb(input logic [7:0] w, input logic [7:0] mask);
    return ^(w & mask);
  endfunction
endpackage

// File: rtl/prbs8_period_meter.sv
// prbs8_period_meter: counts bits between recurrences of the window captured at lock entry
module prbs8_period_meter (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       en,
  input  logic [7:0] ref_w,
  input  logic [7:0] w_next,
  output logic [8:0] period,
  output logic       period_vld
);
  logic [7:0] ref_q;
  logic [8:0] cnt;
  logic hit;
  // a saturated counter cannot represent the length, so it never reports
  assign hit = w_next == ref_q && ~&cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ref_q <= '0;
      cnt <= '0;
      period <= '0;
      period_vld <= 1'b0;
    end else if (start) begin
      ref_q <= ref_w;
      cnt <= '0;
      period_vld <= 1'b0;
    end else if (en) begin
      cnt <= hit ? '0 : cnt + {8'd0, ~&cnt};
      if (hit) begin
        period <= cnt + 1'b1;
        period_vld <= 1'b1;
      end
    end
endmodule

// File: rtl/prbs8_checker.sv
// prbs8_checker: self-synchronising PRBS8 receiver with bit-error counter and period meter.
// Define PRBS8_CHK_INV_EN to also hunt for and lock onto an inverted-polarity stream.
module prbs8_checker
  import prbs8_pkg::*;
#(
  parameter int LOCK_CNT = LOCK_CNT_DEF,
  parameter int UNLOCK_ERRS = UNLOCK_ERRS_DEF,
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       mask,
  input  logic             rx_bit,
  input  logic             rx_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [8:0]       period,
  output logic             period_vld,
  output logic             inverted
);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int RW = $clog2(UNLOCK_ERRS + 1);
  state_t state;
  logic [7:0] w, w_sh, w_lock, w_entry;
  logic [2:0] fill_cnt;
  logic [GW-1:0] good, good_nx;
  logic [RW-1:0] run, run_nx;
  logic p, good_done, inv_hit, inv_win, start, lock_err, unlock;
  always_comb begin
    p = prbs8_fb(w, mask);
    w_sh = {w[6:0], rx_bit};
    w_lock = {w[6:0], p};
    good_nx = (rx_bit == p && |w) ? good + 1'b1 : '0;
    good_done = good_nx == GW'(LOCK_CNT);
    inv_win = inv_hit && !good_done;
    start = rx_valid && state == HUNT && (good_done || inv_win);
    w_entry = inv_win ? ~w_sh : w_sh;
    lock_err = rx_valid && state == LOCK && ((rx_bit ^ inverted) != p);
    run_nx = lock_err ? run + 1'b1 : '0;
    unlock = lock_err && run_nx == RW'(UNLOCK_ERRS);
  end
`ifdef PRBS8_CHK_INV_EN
  logic [GW-1:0] good_inv, good_inv_nx;
  // the inverted hunt runs on ~w so that LOCK always regenerates in true polarity
  assign good_inv_nx = (rx_bit != prbs8_fb(~w, mask) && ~&w) ? good_inv + 1'b1 : '0;
  assign inv_hit = good_inv_nx == GW'(LOCK_CNT);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      good_inv <= '0;
      inverted <= 1'b0;
    end else if (rx_valid) begin
      good_inv <= state == HUNT ? good_inv_nx : '0;
      inverted <= start ? inv_win : unlock ? 1'b0 : inverted;
    end
`else
  assign inv_hit = 1'b0;
  assign inverted = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= FILL;
      w <= '0;
      fill_cnt <= '0;
      good <= '0;
      run <= '0;
      locked <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt <= '0;
    end else begin
      err_pulse <= lock_err;
      err_cnt <= clr_cnt ? '0 : (lock_err && !(&err_cnt)) ? err_cnt + 1'b1 : err_cnt;
      if (rx_valid) begin
        fill_cnt <= state == FILL ? fill_cnt + 1'b1 : '0;
        good <= state == HUNT ? good_nx : '0;
        run <= state == LOCK ? run_nx : '0;
        case (state)
          FILL: begin
            w <= w_sh;
            if (fill_cnt == 3'd7) state <= HUNT;
          end
          HUNT: begin
            w <= start ? w_entry : w_sh;
            if (start) begin
              state <= LOCK;
              locked <= 1'b1;
            end
          end
          LOCK: begin
            w <= w_lock;
            if (unlock) begin
              state <= FILL;
              locked <= 1'b0;
            end
          end
          default: state <= FILL;
        endcase
      end
    end
  prbs8_period_meter u_meter (
    .clk(clk),
    .rst(rst),
    .start(start),
    .en(rx_valid && state == LOCK),
    .ref_w(w_entry),
    .w_next(w_lock),
    .period(period),
    .period_vld(period_vld)
  );
endmodule

// File: tb/tb_prbs8_checker.sv
// tb_prbs8_checker: scoreboard bench feeding a reference PRBS8 stream (mask e1, seed 01) to prbs8_checker.
module tb_prbs8_checker;
  logic clk = 1'b0, rst = 1'b0;
  logic [7:0] mask = 8'he1;
  logic rx_bit = 1'b0, rx_valid = 1'b0, clr_cnt = 1'b0;
  logic locked, err_pulse, period_vld, inverted;
  logic [15:0] err_cnt;
  logic [8:0] period;
  int checks = 0, errors = 0;
  logic [7:0] gs;
  typedef struct {logic locked; logic pulse; logic chk_vld; logic vld;} exp_t;
  exp_t exp_q[$];
  exp_t e;

  prbs8_checker dut (
    .clk(clk), .rst(rst), .mask(mask), .rx_bit(rx_bit), .rx_valid(rx_valid), .clr_cnt(clr_cnt),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .period(period),
    .period_vld(period_vld), .inverted(inverted)
  );

  always #5 clk = ~clk;

  task automatic gen(output logic b);
    b = gs[7];
    gs = {gs[6:0], ^(gs & 8'he1)};
  endtask

  task automatic drive(input logic b, input logic v, input logic c);
    rx_bit = b;
    rx_valid = v;
    clr_cnt = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    rx_valid = 1'b0;
    clr_cnt = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #1;
    checks++;
    if ({locked, err_pulse, period_vld, inverted} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000", {locked, err_pulse, period_vld, inverted});
    end
    checks++;
    if (err_cnt !== 16'd0 || period !== 9'd0) begin
      errors++;
      $display("FAIL reset_counts got err_cnt=%0d period=%0d want 0 0", err_cnt, period);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_lock;
    logic b;
    gs = 8'h01;
    for (int i = 1; i <= 24; i++) begin
      gen(b);
      exp_q.push_back('{i >= 24, 1'b0, 1'b0, 1'b0});
      drive(b, 1'b1, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (locked !== e.locked || err_pulse !== e.pulse) begin
        errors++;
        $display("FAIL lock bit %0d got locked=%b pulse=%b want %b %b", i, locked, err_pulse, e.locked, e.pulse);
      end
    end
    checks++;
    if (err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL lock_err_cnt got %0d want 0", err_cnt);
    end
  endtask

  task automatic test_period;
    logic b;
    for (int k = 1; k <= 600; k++) begin
      gen(b);
      exp_q.push_back('{1'b1, 1'b0, 1'b1, k >= 255});
      drive(b, 1'b1, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (locked !== e.locked || err_pulse !== e.pulse || (e.chk_vld && period_vld !== e.vld) ||
          (e.vld && period !== 9'd255)) begin
        errors++;
        $display("FAIL period bit %0d got locked=%b pulse=%b vld=%b period=%0d want %b %b %b 255",
                 k, locked, err_pulse, period_vld, period, e.locked, e.pulse, e.vld);
      end
    end
  endtask

  task automatic test_single_error;
    logic b;
    for (int i = 1; i <= 120; i++) begin
      gen(b);
      exp_q.push_back('{1'b1, i == 100, 1'b0, 1'b0});
      drive(b ^ (i == 100), 1'b1, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (locked !== e.locked || err_pulse !== e.pulse) begin
        errors++;
        $display("FAIL single_error bit %0d got locked=%b pulse=%b want %b %b", i, locked, err_pulse, e.locked, e.pulse);
      end
    end
    checks++;
    if (err_cnt !== 16'd1) begin
      errors++;
      $display("FAIL single_error_cnt got %0d want 1", err_cnt);
    end
  endtask

  task automatic test_unlock;
    logic b;
    exp_q.push_back('{1'b1, 1'b0, 1'b0, 1'b0});
    drive(1'b0, 1'b0, 1'b1);
    e = exp_q.pop_front();
    checks++;
    if (locked !== e.locked || err_pulse !== e.pulse || err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL idle_clear got locked=%b pulse=%b err_cnt=%0d want 1 0 0", locked, err_pulse, err_cnt);
    end
    for (int i = 1; i <= 28; i++) begin
      gen(b);
      exp_q.push_back('{i < 4 || i >= 28, i <= 4, 1'b0, 1'b0});
      drive(b ^ (i <= 4), 1'b1, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (locked !== e.locked || err_pulse !== e.pulse) begin
        errors++;
        $display("FAIL unlock bit %0d got locked=%b pulse=%b want %b %b", i, locked, err_pulse, e.locked, e.pulse);
      end
    end
    for (int i = 0; i < 10; i++) begin
      gen(b);
      drive(b, 1'b1, 1'b0);
    end
    checks++;
    if (err_cnt !== 16'd4 || locked !== 1'b1) begin
      errors++;
      $display("FAIL unlock_retained got err_cnt=%0d locked=%b want 4 1", err_cnt, locked);
    end
    gen(b);
    drive(b, 1'b1, 1'b1);
    checks++;
    if (err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL unlock_clear got %0d want 0", err_cnt);
    end
  endtask

  task automatic test_clr_collide;
    logic b;
    gen(b);
    exp_q.push_back('{1'b1, 1'b1, 1'b0, 1'b0});
    drive(~b, 1'b1, 1'b1);
    e = exp_q.pop_front();
    checks++;
    if (locked !== e.locked || err_pulse !== e.pulse || err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL clr_collide got locked=%b pulse=%b err_cnt=%0d want 1 1 0", locked, err_pulse, err_cnt);
    end
  endtask

  task automatic test_zero_stream;
    do_reset();
    for (int i = 1; i <= 100; i++) begin
      exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b0});
      drive(1'b0, 1'b1, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (locked !== e.locked || err_pulse !== e.pulse) begin
        errors++;
        $display("FAIL zero_stream bit %0d got locked=%b pulse=%b want 0 0", i, locked, err_pulse);
      end
    end
  endtask

  task automatic test_gaps;
    logic b;
    int n = 0;
    do_reset();
    gs = 8'h01;
    for (int c = 0; c < 60; c++) begin
      if (c % 2 == 0) begin
        gen(b);
        n++;
        exp_q.push_back('{n >= 24, 1'b0, 1'b0, 1'b0});
        drive(b, 1'b1, 1'b0);
      end else begin
        exp_q.push_back('{n >= 24, 1'b0, 1'b0, 1'b0});
        drive(1'($urandom), 1'b0, 1'b0);
      end
      e = exp_q.pop_front();
      checks++;
      if (locked !== e.locked || err_pulse !== e.pulse) begin
        errors++;
        $display("FAIL gaps cycle %0d valid_bits %0d got locked=%b pulse=%b want %b %b", c, n, locked, err_pulse, e.locked, e.pulse);
      end
    end
  endtask

  task automatic test_reset_mid_lock;
    logic b;
    for (int i = 1; i <= 6; i++) begin
      gen(b);
      exp_q.push_back('{1'b1, i % 2 == 1, 1'b0, 1'b0});
      drive(b ^ (i % 2 == 1), 1'b1, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (locked !== e.locked || err_pulse !== e.pulse) begin
        errors++;
        $display("FAIL pre_reset bit %0d got locked=%b pulse=%b want %b %b", i, locked, err_pulse, e.locked, e.pulse);
      end
    end
    checks++;
    if (err_cnt !== 16'd3) begin
      errors++;
      $display("FAIL pre_reset_cnt got %0d want 3", err_cnt);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({locked, err_pulse, period_vld, inverted} !== 4'b0 || err_cnt !== 16'd0 || period !== 9'd0) begin
      errors++;
      $display("FAIL async_reset got flags=%b err_cnt=%0d period=%0d want 0000 0 0",
               {locked, err_pulse, period_vld, inverted}, err_cnt, period);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_inverted;
    logic b;
    do_reset();
    gs = 8'h01;
    for (int i = 1; i <= 54; i++) begin
      gen(b);
`ifdef PRBS8_CHK_INV_EN
      exp_q.push_back('{i >= 24, 1'b0, 1'b0, 1'b0});
`else
      exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b0});
`endif
      drive(~b, 1'b1, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (locked !== e.locked || err_pulse !== e.pulse) begin
        errors++;
        $display("FAIL inverted bit %0d got locked=%b pulse=%b want %b %b", i, locked, err_pulse, e.locked, e.pulse);
      end
    end
    checks++;
`ifdef PRBS8_CHK_INV_EN
    if (inverted !== 1'b1 || err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL inverted_flag got inverted=%b err_cnt=%0d want 1 0", inverted, err_cnt);
    end
`else
    if (inverted !== 1'b0 || err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL inverted_flag got inverted=%b err_cnt=%0d want 0 0", inverted, err_cnt);
    end
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lock();
    test_period();
    test_single_error();
    test_unlock();
    test_clr_collide();
    test_zero_stream();
    test_gaps();
    test_reset_mid_lock();
    test_inverted();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
